// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display controller: display modes,
// the blank pattern and the active-low g..a hex glyph table.
package seg7_pkg;

  typedef enum logic [1:0] {
    MODE_HEX = 2'd0,
    MODE_LZB = 2'd1,
    MODE_OFF = 2'd2
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 15 is the leftmost entry, index 0 the rightmost.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/decode_hex.sv
// Nibble to active-low seven-segment glyph (bit order g..a).
module decode_hex
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_nib];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller: handshake-loaded digit latch, leading-zero
// blanking, display-off mode and per-digit blinking from an internal prescaler.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [4*NUM_DIGITS-1:0] wr_data_i,
  input  logic [1:0]              wr_mode_i,
  input  logic [NUM_DIGITS-1:0]   wr_blink_i,
  input  logic                    hold_i,
  output logic [7*NUM_DIGITS-1:0] seg_o,
  output logic                    blink_phase_o
);

  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [4*NUM_DIGITS-1:0]        r_data;
  logic [1:0]                     r_mode;
  logic [NUM_DIGITS-1:0]          r_blink;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_phase;
  logic [7*NUM_DIGITS-1:0]        r_seg;

  logic                           w_accept;
  logic [NUM_DIGITS-1:0]          w_lead;
  logic [NUM_DIGITS-1:0][6:0]     w_glyph;
  logic [NUM_DIGITS-1:0][6:0]     w_seg_nxt;

  assign wr_ready_o    = ~hold_i & ~rst_i;
  assign w_accept      = wr_valid_i & wr_ready_o;
  assign seg_o         = r_seg;
  assign blink_phase_o = r_phase;

  // Stage 0: digit latch loaded on accepted handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_mode  <= MODE_OFF;
      r_blink <= '0;
    end else if (w_accept) begin
      r_data  <= wr_data_i;
      r_mode  <= wr_mode_i;
      r_blink <= wr_blink_i;
    end
  end

  // Restart the blink cycle on every accepted write so new data shows at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    decode_hex u_dec (
      .i_nib (r_data[4*g +: 4]),
      .o_seg (w_glyph[g])
    );
  end

  // w_lead[i] is set when digit i or any more significant digit is non-zero
  always_comb begin
    logic v_scan;
    v_scan = 1'b0;
    w_lead = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_scan    = v_scan | (r_data[4*i +: 4] != 4'd0);
      w_lead[i] = v_scan;
    end
    w_lead[0] = 1'b1;
  end

  always_comb begin
    w_seg_nxt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_seg_nxt[i] = w_glyph[i];
      case (r_mode)
        MODE_HEX: w_seg_nxt[i] = w_glyph[i];
        MODE_LZB: if (!w_lead[i]) w_seg_nxt[i] = SEG_BLANK;
        default:  w_seg_nxt[i] = SEG_BLANK;
      endcase
      if (r_phase && r_blink[i]) w_seg_nxt[i] = SEG_BLANK;
    end
  end

  // Stage 1: registered segment outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_seg <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_seg <= w_seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomised bench for seg7_display_ctrl with a cycle-level behavioural model.
module tb_seg7_display_ctrl;

  localparam int ND = 8;
  localparam int BD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [4*ND-1:0] wr_data = '0;
  logic [1:0]      wr_mode = 2'd0;
  logic [ND-1:0]   wr_blink = '0;
  logic            hold = 1'b0;
  logic [7*ND-1:0] seg;
  logic            blink_phase;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]     m_data;
  logic [1:0]      m_mode;
  logic [7:0]      m_blink;
  int              m_since;
  logic [55:0]     exp_seg;

  localparam logic [55:0] L_BLANK = {8{7'h7F}};
  localparam logic [55:0] L_HEX   = {{6{7'h40}}, 7'h08, 7'h12};
  localparam logic [55:0] L_LZB   = {{6{7'h7F}}, 7'h08, 7'h12};
  localparam logic [55:0] L_ZERO  = {{7{7'h7F}}, 7'h40};
  localparam logic [55:0] L_DARK0 = {{6{7'h40}}, 7'h08, 7'h7F};
  localparam logic [55:0] L_1TO8  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [55:0] L_EIGHT = {{7{7'h40}}, 7'h00};

  seg7_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_data_i     (wr_data),
    .wr_mode_i     (wr_mode),
    .wr_blink_i    (wr_blink),
    .hold_i        (hold),
    .seg_o         (seg),
    .blink_phase_o (blink_phase)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero when it and everything above it is zero.
  function automatic logic [55:0] model_seg(input logic [31:0] d, input logic [1:0] m,
                                            input logic [7:0] b, input bit ph);
    logic [55:0] r;
    logic [6:0]  g;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      g = glyph(d[4*i +: 4]);
      if (m >= 2'd2) g = 7'h7F;
      else if (m == 2'd1 && i > 0 && (d >> (4*i)) == 32'd0) g = 7'h7F;
      if (ph && b[i]) g = 7'h7F;
      r[7*i +: 7] = g;
    end
    return r;
  endfunction

  function automatic bit phase_of(input int since);
    return ((since / BD) % 2) == 1;
  endfunction

  // Phase is derived from cycles elapsed since the last accept or reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  = '0;
      m_mode  = 2'd2;
      m_blink = '0;
      m_since = 0;
      exp_seg = L_BLANK;
    end else begin
      exp_seg = model_seg(m_data, m_mode, m_blink, phase_of(m_since));
      if (wr_valid && !hold) begin
        m_data  = wr_data;
        m_mode  = wr_mode;
        m_blink = wr_blink;
        m_since = 0;
      end else begin
        m_since++;
      end
    end
  end

  task automatic chk(input string nm, input logic [55:0] act, input logic [55:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("seg_cycle", seg, exp_seg);
    chk("phase_cycle", {55'd0, blink_phase}, {55'd0, (rst ? 1'b0 : phase_of(m_since))});
    chk("ready_cycle", {55'd0, wr_ready}, {55'd0, (!hold && !rst)});
  end

  task automatic wr(input logic [31:0] d, input logic [1:0] m, input logic [7:0] b);
    @(posedge clk); #2;
    wr_valid = 1'b1; wr_data = d; wr_mode = m; wr_blink = b;
    @(posedge clk); #2;
    wr_valid = 1'b0;
  endtask

  task automatic after1;
    @(posedge clk); #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_seg", seg, L_BLANK);
    chk("reset_ready", {55'd0, wr_ready}, 56'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {55'd0, wr_ready}, 56'd1);

    wr(32'h0000_00A5, 2'd0, 8'h00); after1;
    chk("hex_a5", seg, L_HEX);
    chk("model_hex_a5", exp_seg, L_HEX);

    wr(32'h0000_00A5, 2'd1, 8'h00); after1;
    chk("lzb_a5", seg, L_LZB);
    chk("model_lzb_a5", exp_seg, L_LZB);

    wr(32'h0000_0000, 2'd1, 8'h00); after1;
    chk("lzb_zero", seg, L_ZERO);

    wr(32'h0000_00A5, 2'd0, 8'h01); after1;
    chk("blink_visible", seg, L_HEX);
    repeat (4) @(posedge clk);
    #2;
    chk("blink_dark", seg, L_DARK0);
    chk("model_blink_dark", exp_seg, L_DARK0);
    chk("phase_dark", {55'd0, blink_phase}, 56'd1);
    wr(32'h0000_00A5, 2'd0, 8'h01); after1;
    chk("write_mid_dark", seg, L_HEX);
    chk("phase_restart", {55'd0, blink_phase}, 56'd0);

    @(posedge clk); #2;
    hold = 1'b1; wr_valid = 1'b1;
    wr_data = 32'h1234_5678; wr_mode = 2'd0; wr_blink = 8'h00;
    #1;
    chk("hold_ready", {55'd0, wr_ready}, 56'd0);
    repeat (5) @(posedge clk);
    #2;
    hold = 1'b0;
    @(posedge clk); #2;
    wr_valid = 1'b0;
    after1;
    chk("hold_release", seg, L_1TO8);

    wr(32'hFFFF_FFFF, 2'd3, 8'h00); after1;
    chk("mode_reserved", seg, L_BLANK);
    wr(32'h0000_00A5, 2'd2, 8'h00); after1;
    chk("mode_off", seg, L_BLANK);

    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      wr_valid = ($urandom_range(0, 3) == 0);
      hold     = ($urandom_range(0, 3) == 0);
      wr_data  = $urandom >> (4 * $urandom_range(0, 8));
      wr_mode  = 2'($urandom_range(0, 3));
      wr_blink = 8'($urandom);
    end
    @(posedge clk); #2;
    wr_valid = 1'b0; hold = 1'b0;

    wr(32'h0000_00A5, 2'd0, 8'hFF);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", seg, L_BLANK);
    chk("async_rst_phase", {55'd0, blink_phase}, 56'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h0000_0008; wr_mode = 2'd0; wr_blink = 8'h00;
    @(posedge clk); #2;
    wr_valid = 1'b0;
    after1;
    chk("first_accept_after_rst", seg, L_EIGHT);

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Parametrised seven-segment display controller that sits between the pipeline core's hex I/O registers and the board's HEX digit pins. It replaces the fixed eight-instance hex decode at the top level. Each digit has a registered data latch written through a valid/ready handshake. The block adds leading-zero blanking, a display-off mode and per-digit blinking driven by an internal prescaler.

## Interface
- NUM_DIGITS, 8, number of digits driven (1..16)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥2)
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- wr_valid_i  in  1  update request
- wr_ready_o  out  1  update accepted when high with wr_valid_i
- wr_data_i  in  4*NUM_DIGITS  nibble per digit, digit 0 in [3:0]
- wr_mode_i  in  2  display mode (seg7_pkg::mode_e)
- wr_blink_i  in  NUM_DIGITS  per-digit blink enable
- hold_i  in  1  freezes display contents, blocks updates
- seg_o  out  7*NUM_DIGITS  active-low segments g..a per digit, digit 0 in [6:0]
- blink_phase_o  out  1  current blink phase, 1 = blinking digits dark

## Operation
- Modes:
  - MODE_HEX (2'd0): every digit shows its nibble.
  - MODE_LZB (2'd1): zero digits are blanked from the MSB down to the first non-zero digit; digit 0 is always shown.
  - MODE_OFF (2'd2): all digits blank.
  - 2'd3 is reserved and behaves as MODE_OFF.
- Blank pattern is 7'h7F. Glyphs come from the shared hex decode table (0 → 7'h40, 8 → 7'h00, F → 7'h0E).
- Handshake:
  - wr_ready_o = !hold_i; it is low throughout reset.
  - Accept = wr_valid_i & wr_ready_o. On accept, data_q, mode_q and blink_q are loaded at that clock edge.
  - wr_valid_i without ready is ignored. Nothing is queued.
- Blink prescaler:
  - cnt_q counts 0..BLINK_DIV-1. At BLINK_DIV-1 it wraps to 0 and toggles phase_q.
  - When phase_q = 1, digits with blink_q[i] = 1 are forced blank. This is applied after mode blanking.
  - An accepted write clears cnt_q and phase_q in the same edge, so new data is visible immediately.
  - While hold_i = 1, cnt_q and phase_q keep running.
- Reset values: data_q = 0, mode_q = MODE_OFF, blink_q = 0, cnt_q = 0, phase_q = 0, seg_o = all 7'h7F, blink_phase_o = 0.

## Timing
- seg_o is registered from data_q, mode_q, blink_q and phase_q.
  - Accept at edge N → seg_o shows the new value after edge N+1 (2-cycle write-to-pin latency).
- A phase_q toggle at edge N is reflected on seg_o after edge N+1.
- Back-to-back accepts on consecutive cycles are legal. Each overwrites the previous one, and seg_o follows one edge behind.
- hold_i rising in the same cycle as wr_valid_i: no accept.
- Reset asserted mid-blink or mid-write: all state returns to reset values asynchronously. The first accept is possible on the first edge after rst_i falls.
- With BLINK_DIV = d, the blink period is 2·d cycles exactly. The counter width is $clog2(BLINK_DIV).

## Structure
- seg7_pkg holds:
  - mode_e (MODE_HEX, MODE_LZB, MODE_OFF)
  - SEG_BLANK = 7'h7F
  - the 16-entry HEX_GLYPH constant array (active-low, g..a)
- Sub-module: the existing decode_hex, instantiated NUM_DIGITS times via generate on data_q nibbles. Its outputs are masked and then registered here.
- Leading-zero mask is computed combinationally: a prefix-OR scan from MSB over the (data_q[i] != 0) flags.

## Test plan
Bench parameters: NUM_DIGITS = 8, BLINK_DIV = 4.
- Reset → seg_o = {8{7'h7F}}, wr_ready_o = 0 during reset and 1 after. Then write data 32'h0000_00A5, mode HEX → two edges later, digit0 = 5's glyph 7'h12, digit1 = A's glyph 7'h08, digits 2..7 = 7'h40.
- Same data, mode LZB → digits 2..7 = 7'h7F, digits 0..1 unchanged. Data 0 in LZB → only digit0 = 7'h40.
- Write with blink = 8'h01 → phase_q toggles every 4 cycles and digit0 alternates glyph/7'h7F with period 8. A write issued mid-dark-phase → digit0 visible 2 edges later and counter restarted.
- hold_i = 1 with wr_valid_i = 1, new data → seg_o unchanged and wr_ready_o = 0. On hold release with valid still high → accept, new data shown 2 edges later.
- Mode 2'd3 and MODE_OFF → all 7'h7F. Assert rst_i mid-blink → seg_o = 7'h7F immediately (asynchronously) and blink_phase_o = 0.
